// File: rtl/sequencer_pkg.sv
// Shared definitions for the program sequencer: default address width and next-PC source encoding.
package sequencer_pkg;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [2:0] {
    SRC_BRANCH,
    SRC_J,
    SRC_JR,
    SRC_CALL,
    SRC_RET,
    SRC_INC,
    SRC_HOLD
  } next_src_e;
endpackage

// File: rtl/program_sequencer_if.sv
// Control/status bundle between a controller (master) and the program sequencer (slave).
interface program_sequencer_if
  import sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic              Stall;
  logic              Halt;
  logic              Branch;
  logic              Zero;
  logic              J;
  logic              Jr;
  logic              Call;
  logic              Ret;
  logic              ClearErr;
  logic [ADDR_W-1:0] AddressJump;
  logic [ADDR_W-1:0] pc_out;
  logic [DEPTH_W-1:0] StackDepth;
  logic              StackFull;
  logic              StackEmpty;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Stall, Halt, Branch, Zero, J, Jr, Call, Ret, ClearErr, AddressJump,
    input  pc_out, StackDepth, StackFull, StackEmpty, Overflow, Underflow
  );

  modport slave (
    input  Stall, Halt, Branch, Zero, J, Jr, Call, Ret, ClearErr, AddressJump,
    output pc_out, StackDepth, StackFull, StackEmpty, Overflow, Underflow
  );
endinterface

// File: rtl/program_sequencer_return_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_idx;

  // wr_ptr points at the next free slot, which when full is also the oldest entry.
  assign top_idx = wr_ptr - 1'b1;
  assign top     = mem[top_idx];
  assign full    = (depth == ($clog2(DEPTH) + 1)'(DEPTH));
  assign empty   = (depth == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      depth  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) depth <= depth + 1'b1;
    end else if (pop) begin
      wr_ptr <= top_idx;
      depth  <= depth - 1'b1;
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// Program counter with prioritised redirects, halt/stall and a return stack; one-cycle redirect latency.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  program_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  next_src_e          src;
  logic [ADDR_W-1:0]  pc_q, pc_d, top;
  logic [DEPTH_W-1:0] depth;
  logic               push, pop, full, empty;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    src = SRC_HOLD;
    if (!bus.Stall) begin
      if (bus.Branch && bus.Zero) src = SRC_BRANCH;
      else if (bus.J)             src = SRC_J;
      else if (bus.Jr)            src = SRC_JR;
      else if (bus.Call)          src = SRC_CALL;
      else if (bus.Ret)           src = SRC_RET;
      else if (!bus.Halt)         src = SRC_INC;
    end
  end

  assign push = (src == SRC_CALL);
  assign pop  = (src == SRC_RET) && !empty;

  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_BRANCH, SRC_J, SRC_JR, SRC_CALL: pc_d = bus.AddressJump;
      SRC_RET:  pc_d = empty ? pc_q : top;
      SRC_INC:  pc_d = pc_q + 1'b1;
      default:  pc_d = pc_q;
    endcase
  end

  // A set event in the same cycle beats ClearErr; a stalled cycle keeps the flags as they are.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!bus.Stall) begin
      ovf_d = (push && full) || (ovf_q && !bus.ClearErr);
      unf_d = ((src == SRC_RET) && empty) || (unf_q && !bus.ClearErr);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  return_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + 1'b1),
    .top   (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  assign bus.pc_out     = pc_q;
  assign bus.StackDepth = depth;
  assign bus.StackFull  = full;
  assign bus.StackEmpty = empty;
  assign bus.Overflow   = ovf_q;
  assign bus.Underflow  = unf_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed table, corner sequences and a random run against a queue-based model.
module tb_program_sequencer;
  localparam int AW = 32;
  localparam int SD = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  program_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();

  program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic st, ha, br, z, j, jr, ca, re, cl;
    logic [AW-1:0] aj;
    logic [AW-1:0] e_pc;
    int            e_d;
    logic          e_ovf, e_unf;
  } vec_t;

  vec_t tbl [20];

  // Reference model: PC as a plain number, return stack as a bounded queue.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk [$];
  logic          m_ovf, m_unf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic st, ha, br, z, j, jr, ca, re, cl, input logic [AW-1:0] aj);
    bus.Stall = st; bus.Halt = ha; bus.Branch = br; bus.Zero = z;
    bus.J = j; bus.Jr = jr; bus.Call = ca; bus.Ret = re; bus.ClearErr = cl;
    bus.AddressJump = aj;
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    logic os, us;
    os = 1'b0;
    us = 1'b0;
    if (bus.Stall) return;
    if ((bus.Branch && bus.Zero) || bus.J || bus.Jr) begin
      m_pc = bus.AddressJump;
    end else if (bus.Call) begin
      m_stk.push_back(m_pc + 1);
      if (m_stk.size() > SD) begin
        void'(m_stk.pop_front());
        os = 1'b1;
      end
      m_pc = bus.AddressJump;
    end else if (bus.Ret) begin
      if (m_stk.size() == 0) us = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (!bus.Halt) begin
      m_pc = m_pc + 1;
    end
    m_ovf = os || (m_ovf && !bus.ClearErr);
    m_unf = us || (m_unf && !bus.ClearErr);
  endtask

  task automatic cyc();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    bus.pc_out, m_pc);
    chk({tag, ".depth"}, bus.StackDepth, m_stk.size());
    chk({tag, ".full"},  bus.StackFull, m_stk.size() == SD);
    chk({tag, ".empty"}, bus.StackEmpty, m_stk.size() == 0);
    chk({tag, ".ovf"},   bus.Overflow, m_ovf);
    chk({tag, ".unf"},   bus.Underflow, m_unf);
  endtask

  initial begin
    //             st ha br z  j  jr ca re cl  aj             e_pc           d  ovf unf
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h1,        0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h2,        0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h3,        0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h4,        0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h5,        0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h5,        0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h40,       32'h40,       0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h60,       32'h60,       0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10,       32'h10,       0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80,       32'h80,       1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h11,       0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h11,       0, 0, 1};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h11,       0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h55,       32'h0,        0, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h30,       32'h30,       0, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h30,       0, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h30,       0, 0, 1};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h30,       0, 0, 0};

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    model_reset();
    #2;
    chk("rst.pc",    bus.pc_out, 32'h0);
    chk("rst.depth", bus.StackDepth, 0);
    chk("rst.empty", bus.StackEmpty, 1'b1);
    chk("rst.full",  bus.StackFull, 1'b0);
    chk("rst.ovf",   bus.Overflow, 1'b0);
    chk("rst.unf",   bus.Underflow, 1'b0);
    #10 Reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drv(tbl[i].st, tbl[i].ha, tbl[i].br, tbl[i].z, tbl[i].j, tbl[i].jr,
          tbl[i].ca, tbl[i].re, tbl[i].cl, tbl[i].aj);
      cyc();
      chk($sformatf("tbl%0d.pc", i),    bus.pc_out, tbl[i].e_pc);
      chk($sformatf("tbl%0d.depth", i), bus.StackDepth, tbl[i].e_d);
      chk($sformatf("tbl%0d.empty", i), bus.StackEmpty, tbl[i].e_d == 0);
      chk($sformatf("tbl%0d.ovf", i),   bus.Overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d.unf", i),   bus.Underflow, tbl[i].e_unf);
    end

    // Nine nested calls from PCs 0..8 overflow an 8-deep stack; returns unwind 9 down to 2.
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    cyc();
    for (int i = 0; i < 9; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0, 0, AW'(i + 1));
      cyc();
    end
    chk("nest.ovf",   bus.Overflow, 1'b1);
    chk("nest.depth", bus.StackDepth, SD);
    chk("nest.full",  bus.StackFull, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
      cyc();
      chk($sformatf("unwind%0d.pc", k), bus.pc_out, AW'(9 - k));
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
    cyc();
    chk("under.pc",  bus.pc_out, 32'h2);
    chk("under.unf", bus.Underflow, 1'b1);
    chk("under.ovf", bus.Overflow, 1'b1);
    drv(0, 1, 0, 0, 0, 0, 0, 0, 1, '0);
    cyc();
    chk("clr.ovf", bus.Overflow, 1'b0);
    chk("clr.unf", bus.Underflow, 1'b0);
    check_model("clr");

    // Reset arriving between edges while a Call is being requested.
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h20);
    cyc();
    chk("prerst.depth", bus.StackDepth, 1);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h99);
    #3 Reset = 1'b0;
    #1;
    chk("arst.pc",    bus.pc_out, 32'h0);
    chk("arst.depth", bus.StackDepth, 0);
    chk("arst.empty", bus.StackEmpty, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    model_reset();
    #2 Reset = 1'b1;
    cyc();
    check_model("postrst");

    for (int n = 0; n < 400; n++) begin
      drv(($urandom_range(7) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
          $urandom_range(1), ($urandom_range(15) == 0), ($urandom_range(15) == 0),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          ($urandom_range(1) == 0) ? AW'($urandom_range(255)) : AW'($urandom));
      cyc();
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
